// File: rtl/even_parity_checker_pkg.sv
// Shared definitions for the even-parity generator/checker pair: FSM state
// encoding and the parity reduction both ends must agree on.
package even_parity_checker_pkg;

  typedef logic state_t;

  localparam state_t ST_RUN   = 1'b0;
  localparam state_t ST_FAULT = 1'b1;

  localparam int PAR_MAX_W = 64;

  // Returns 1 when the vector holds an odd number of ones (even parity broken).
  function automatic logic odd_ones(input logic [PAR_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/even_parity_checker_pipe_reg.sv
// One-entry valid/ready pipeline register holding a checked word and its
// parity-error flag; a new word may load in the same cycle the old one drains.
module parity_pipe_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              err_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              err_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    err_d   = err_q;
    if (valid_q && ready_i) valid_d = 1'b0;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      err_d   = err_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign err_o   = err_q;

endmodule

// File: rtl/even_parity_checker.sv
// Receive-side even-parity checker: flags each word, counts errors, and stalls
// input in FAULT after MAX_CONSEC consecutive bad words until clr_err.
//
// state    | meaning
// ST_RUN   | accepting words whenever the output stage has room
// ST_FAULT | input stalled; registered word still drains; left via clr_err
module even_parity_checker
  import even_parity_checker_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 16,
  parameter int MAX_CONSEC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_par,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  err_count,
  output logic              fault,
  input  logic              clr_err
);

  localparam int CONSEC_W = 8;
  localparam logic [CONSEC_W-1:0] CONSEC_MAX = CONSEC_W'(MAX_CONSEC);
  localparam logic [CNT_W-1:0]    CNT_SAT    = '1;

  state_t               state_q, state_d;
  logic                 sticky_q, sticky_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CONSEC_W-1:0]  consec_q, consec_d;
  logic [PAR_MAX_W-1:0] par_vec;
  logic                 bad;
  logic                 accept;

  assign par_vec = PAR_MAX_W'({in_data, in_par});
  assign bad     = odd_ones(par_vec);
  assign accept  = in_valid && in_ready;

  parity_pipe_reg #(.DATA_W(DATA_W)) u_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (accept),
    .data_i  (in_data),
    .err_i   (bad),
    .ready_i (out_ready),
    .valid_o (out_valid),
    .data_o  (out_data),
    .err_o   (out_err)
  );

  // A bad word accepted alongside clr_err still counts: the error wins.
  always_comb begin
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    consec_d = consec_q;
    if (accept && bad) begin
      sticky_d = 1'b1;
      if (clr_err) begin
        cnt_d    = CNT_W'(1);
        consec_d = CONSEC_W'(1);
      end else begin
        cnt_d    = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
        consec_d = (consec_q >= CONSEC_MAX) ? consec_q : consec_q + CONSEC_W'(1);
      end
    end else if (clr_err) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
      consec_d = '0;
    end else if (accept) begin
      consec_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      consec_q <= '0;
    end else begin
      state_q  <= state_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      consec_q <= consec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (accept && bad && consec_d == CONSEC_MAX) state_d = ST_FAULT;
      ST_FAULT: if (clr_err) state_d = ST_RUN;
    endcase
  end

  always_comb begin
    in_ready = (state_q == ST_RUN) && (!out_valid || out_ready);
    fault    = (state_q == ST_FAULT);
  end

  assign err_sticky = sticky_q;
  assign err_count  = cnt_q;

endmodule

// File: tb/tb_even_parity_checker.sv
// Bench for even_parity_checker: directed scenarios plus random traffic,
// checked through an expected-word queue and a behavioural status model.
module tb_even_parity_checker;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 2;
  localparam int MAXC   = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_par, out_ready, clr_err;
  logic [DATA_W-1:0] in_data;
  logic              in_ready, out_valid, out_err, err_sticky, fault;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  err_count;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W:0] q[$];
  int   m_cnt    = 0;
  int   m_consec = 0;
  bit   m_sticky = 0;
  bit   m_fault  = 0;

  even_parity_checker #(.DATA_W(DATA_W), .CNT_W(CNT_W), .MAX_CONSEC(MAXC)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_par(in_par),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .err_sticky(err_sticky), .err_count(err_count), .fault(fault), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: word is bad when data plus parity bit hold an odd count of ones.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_cnt = 0; m_consec = 0; m_sticky = 0; m_fault = 0;
    end else begin
      bit rdy, acc, bad;
      rdy = !m_fault && (q.size() == 0);
      acc = in_valid && rdy;
      bad = ($countones({in_data, in_par}) % 2) == 1;
      if (acc) q.push_back({bad, in_data});
      if (acc && bad) begin
        m_sticky = 1;
        if (clr_err) begin
          m_cnt = 1; m_consec = 1;
        end else begin
          m_cnt    = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
          m_consec = (m_consec < MAXC) ? m_consec + 1 : MAXC;
        end
        if (m_consec == MAXC) m_fault = 1;
      end else if (clr_err) begin
        m_cnt = 0; m_consec = 0; m_sticky = 0; m_fault = 0;
      end else if (acc) begin
        m_consec = 0;
      end
    end
  end

  // Monitor: compares presented words with the queue head and pops on transfer.
  always @(negedge clk) begin
    chk("out_valid", out_valid, q.size() != 0);
    if (out_valid && q.size() != 0) begin
      chk("out_data", out_data, q[0][DATA_W-1:0]);
      chk("out_err", out_err, q[0][DATA_W]);
      if (out_ready) void'(q.pop_front());
    end
    chk("in_ready", in_ready, !m_fault && (q.size() == 0 || out_ready));
    chk("err_count", err_count, m_cnt);
    chk("err_sticky", err_sticky, m_sticky);
    chk("fault", fault, m_fault);
  end

  task automatic cyc(input bit v, input logic [DATA_W-1:0] d, input bit p,
                     input bit ordy, input bit clr);
    in_valid = v; in_data = d; in_par = p; out_ready = ordy; clr_err = clr;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
  endtask

  localparam logic [DATA_W-1:0] W_A = 32'h3456_789a;
  localparam logic [DATA_W-1:0] W_B = 32'hc464_78ff;

  initial begin
    rst_n = 1'b0; in_valid = 0; in_data = '0; in_par = 0; out_ready = 0; clr_err = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_fault", fault, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;

    cyc(1, W_A, 1, 1, 0);
    chk("good_valid", out_valid, 1);
    chk("good_data", out_data, W_A);
    chk("good_err", out_err, 0);
    chk("good_cnt", err_count, 0);
    cyc(1, W_A, 0, 1, 0);
    chk("bad_err", out_err, 1);
    chk("bad_sticky", err_sticky, 1);
    chk("bad_cnt", err_count, 1);
    cyc(1, W_B, 0, 1, 0);
    chk("next_err", out_err, 0);
    cyc(0, '0, 0, 1, 0);

    // Backpressure: first word held for three cycles, then streaming.
    cyc(1, 32'h0000_0003, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 32'h0000_0007, 1, 0, 0);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold", out_data, 32'h0000_0003);
    end
    cyc(1, 32'h0000_0007, 1, 1, 0);
    cyc(1, 32'h0000_000f, 0, 1, 0);
    cyc(1, 32'h0000_001f, 1, 1, 0);
    chk("bp_last", out_data, 32'h0000_001f);
    cyc(0, '0, 0, 1, 0);

    // Saturation: five bad words interleaved with good ones.
    cyc(0, '0, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(1, W_A, 0, 1, 0);
      cyc(1, W_A, 1, 1, 0);
    end
    chk("sat_cnt", err_count, 3);
    chk("sat_nofault", fault, 0);
    cyc(1, W_A, 0, 1, 1);
    chk("race_cnt", err_count, 1);
    chk("race_sticky", err_sticky, 1);
    chk("race_fault", fault, 0);
    cyc(0, '0, 0, 1, 1);

    // FAULT after four consecutive bad words.
    for (int i = 0; i < 3; i++) cyc(1, W_B, 1, 1, 0);
    chk("pre_fault", fault, 0);
    cyc(1, W_B, 1, 1, 0);
    chk("fault_set", fault, 1);
    chk("fault_in_ready", in_ready, 0);
    chk("fault_word", out_valid, 1);
    cyc(1, W_A, 1, 1, 0);
    chk("fault_drained", out_valid, 0);
    chk("fault_held", fault, 1);
    cyc(0, '0, 0, 1, 1);
    chk("clr_fault", fault, 0);
    chk("clr_cnt", err_count, 0);
    chk("clr_in_ready", in_ready, 1);

    // Async reset while a word is held under backpressure.
    cyc(1, W_A, 0, 0, 0);
    cyc(0, '0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 0);
    chk("arst_err", out_err, 0);
    chk("arst_cnt", err_count, 0);
    chk("arst_sticky", err_sticky, 0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_ready", in_ready, 1);
    cyc(1, W_B, 0, 1, 0);
    chk("arst_accept", out_data, W_B);

    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 1),
          $urandom_range(0, 9) < 7, $urandom_range(0, 99) < 3);
    end
    for (int i = 0; i < 3; i++) cyc(0, '0, 0, 1, 0);
    chk("drain_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
